// File: rtl/parking_pkg.sv
// parking_pkg: shared definitions for the car-park gate controller.
//   park_state_e   controller state encoding
//   SEG_*          active-low 7-segment patterns (bit 0 = segment a ... bit 6 = g)
//   cnt_width()    bits needed for a counter that counts 0..n-1
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PASSWORD,
    WRONG_PASS,
    RIGHT_PASS,
    STOP,
    LOCKOUT
  } park_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/parking_controller_mg_seg7_decoder.sv
// seg7_decoder: BCD digit to active-low 7-segment pattern.
//   bcd   in  4  digit 0..9 (other codes display blank)
//   blank in  1  force all segments off
//   seg   out 7  active-low segments, bit 0 = a
module seg7_decoder
  import parking_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/parking_controller_mg.sv
// parking_controller_mg: car-park entry gate controller with keypad code
// check, occupancy count, wrong-code lockout and code-entry timeout.
// Optional feature macro: TAILGATE_DETECT_EN (builds the STOP state that
// catches a second car following through an open gate).
//   clk, reset        clock; synchronous active-high reset
//   sensor_entrance   car waiting at the gate
//   sensor_exit       car has passed through the gate
//   sensor_leave      one-cycle pulse, a car left the lot
//   code_in/valid     keypad code and its strobe
//   GREEN_LED/RED_LED gate indicators (registered)
//   HEX_1/HEX_2       tens/ones digit, active-low (registered)
//   occupancy, full   car count and full flag
//   locked            high while in lockout
module parking_controller_mg
  import parking_pkg::*;
#(
  parameter int unsigned          PW_WIDTH    = 4,
  parameter logic [PW_WIDTH-1:0]  PASSWORD    = 4'hA,
  parameter int unsigned          CAPACITY    = 8,
  parameter int unsigned          WAIT_CYCLES = 16,
  parameter int unsigned          MAX_TRIES   = 3,
  parameter int unsigned          LOCK_CYCLES = 32,
  parameter int unsigned          BLINK_DIV   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              sensor_entrance,
  input  logic                              sensor_exit,
  input  logic                              sensor_leave,
  input  logic [PW_WIDTH-1:0]               code_in,
  input  logic                              code_valid,
  output logic                              GREEN_LED,
  output logic                              RED_LED,
  output logic [6:0]                        HEX_1,
  output logic [6:0]                        HEX_2,
  output logic [$clog2(CAPACITY+1)-1:0]     occupancy,
  output logic                              full,
  output logic                              locked
);

  localparam int unsigned OCC_W  = $clog2(CAPACITY + 1);
  localparam int unsigned TRY_W  = cnt_width(MAX_TRIES + 1);
  localparam int unsigned WAIT_W = cnt_width(WAIT_CYCLES);
  localparam int unsigned LOCK_W = cnt_width(LOCK_CYCLES);
  localparam int unsigned BLNK_W = cnt_width(BLINK_DIV);

  park_state_e       state_q, state_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [TRY_W-1:0]  tries_q, tries_d, tries_inc;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [BLNK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;
  logic              green_q, green_d;
  logic              red_q, red_d;
  logic [6:0]        hex1_q, hex1_d;
  logic [6:0]        hex2_q, hex2_d;

  logic              full_now, admit, code_ok, code_bad, too_many;
  logic [31:0]       occ_ext;
  logic [3:0]        tens_d, ones_d;
  logic [6:0]        tens_seg, ones_seg;

  // Next state, tries and occupancy
  always_comb begin
    state_d   = state_q;
    tries_inc = tries_q + TRY_W'(1);
    tries_d   = tries_q;
    admit     = 1'b0;
    full_now  = (occ_q == OCC_W'(CAPACITY));
    code_ok   = code_valid && (code_in == PASSWORD);
    code_bad  = code_valid && (code_in != PASSWORD);
    too_many  = (tries_inc >= TRY_W'(MAX_TRIES));

    // A strobe always wins over timeout / sensor release in the same cycle.
    case (state_q)
      IDLE: begin
        if (sensor_entrance && !full_now) state_d = WAIT_PASSWORD;
      end
      WAIT_PASSWORD, WRONG_PASS: begin
        if (code_ok) begin
          state_d = RIGHT_PASS;
          tries_d = '0;
        end else if (code_bad) begin
          tries_d = tries_inc;
          state_d = too_many ? LOCKOUT : WRONG_PASS;
        end else if (state_q == WAIT_PASSWORD) begin
          if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) state_d = IDLE;
        end else if (!sensor_entrance) begin
          state_d = IDLE;
        end
      end
      RIGHT_PASS: begin
        if (sensor_exit) begin
          admit = 1'b1;
`ifdef TAILGATE_DETECT_EN
          state_d = sensor_entrance ? STOP : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef TAILGATE_DETECT_EN
      STOP: begin
        if (code_ok) begin
          tries_d = '0;
          if (!full_now) state_d = RIGHT_PASS;
        end else if (code_bad) begin
          tries_d = tries_inc;
          if (too_many) state_d = LOCKOUT;
        end else if (!sensor_entrance) begin
          state_d = IDLE;
        end
      end
`endif
      LOCKOUT: begin
        if (lock_q == LOCK_W'(LOCK_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Every return to IDLE starts a fresh try count.
    if (state_d == IDLE) tries_d = '0;

    occ_d = occ_q;
    if (admit && !sensor_leave) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!admit && sensor_leave && (occ_q != '0)) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Timers and blink divider
  always_comb begin
    wait_d      = (state_q == WAIT_PASSWORD) ? wait_q + WAIT_W'(1) : '0;
    lock_d      = (state_q == LOCKOUT) ? lock_q + LOCK_W'(1) : '0;
    blink_cnt_d = blink_cnt_q + BLNK_W'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BLNK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  // LEDs and display follow the state being entered so that the registered
  // outputs line up with the registered state.
  always_comb begin
    green_d = 1'b0;
    red_d   = 1'b0;
    case (state_d)
      IDLE:                   red_d   = sensor_entrance && full_now;
      WAIT_PASSWORD, LOCKOUT: red_d   = 1'b1;
      WRONG_PASS, STOP:       red_d   = blink_d;
      RIGHT_PASS:             green_d = blink_d;
      default:                red_d   = 1'b0;
    endcase

    occ_ext = 32'(occ_d);
    tens_d  = 4'(occ_ext / 32'd10);
    ones_d  = 4'(occ_ext % 32'd10);

    hex1_d = tens_seg;
    hex2_d = ones_seg;
    if (state_d == LOCKOUT) begin
      hex1_d = SEG_L;
      hex2_d = SEG_O;
    end
  end

  seg7_decoder u_tens (
    .bcd   (tens_d),
    .blank (tens_d == 4'd0),
    .seg   (tens_seg)
  );

  seg7_decoder u_ones (
    .bcd   (ones_d),
    .blank (1'b0),
    .seg   (ones_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      occ_q       <= '0;
      tries_q     <= '0;
      wait_q      <= '0;
      lock_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      green_q     <= 1'b0;
      red_q       <= 1'b0;
      hex1_q      <= SEG_BLANK;
      hex2_q      <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      tries_q     <= tries_d;
      wait_q      <= wait_d;
      lock_q      <= lock_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      green_q     <= green_d;
      red_q       <= red_d;
      hex1_q      <= hex1_d;
      hex2_q      <= hex2_d;
    end
  end

  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign HEX_1     = hex1_q;
  assign HEX_2     = hex2_q;
  assign occupancy = occ_q;
  assign full      = (occ_q == OCC_W'(CAPACITY));
  assign locked    = (state_q == LOCKOUT);

endmodule

// File: tb/tb_parking_controller_mg.sv
// tb_parking_controller_mg: scoreboard bench for parking_controller_mg.
// Directed scenarios followed by random traffic; a reference model predicts
// every output after each clock and a monitor compares the DUT against it.
// Honours TAILGATE_DETECT_EN the same way as the design.
module tb_parking_controller_mg;

  localparam int unsigned PW_WIDTH    = 4;
  localparam logic [3:0]  PASSWORD    = 4'hA;
  localparam int unsigned CAPACITY    = 8;
  localparam int unsigned WAIT_CYCLES = 16;
  localparam int unsigned MAX_TRIES   = 3;
  localparam int unsigned LOCK_CYCLES = 32;
  localparam int unsigned BLINK_DIV   = 4;
  localparam int unsigned OCC_W       = $clog2(CAPACITY + 1);
`ifdef TAILGATE_DETECT_EN
  localparam bit TAILGATE = 1'b1;
`else
  localparam bit TAILGATE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sensor_entrance = 1'b0;
  logic             sensor_exit = 1'b0;
  logic             sensor_leave = 1'b0;
  logic [3:0]       code_in = 4'h0;
  logic             code_valid = 1'b0;
  logic             GREEN_LED, RED_LED, full, locked;
  logic [6:0]       HEX_1, HEX_2;
  logic [OCC_W-1:0] occupancy;

  always #5 clk = ~clk;

  parking_controller_mg #(
    .PW_WIDTH    (PW_WIDTH),
    .PASSWORD    (PASSWORD),
    .CAPACITY    (CAPACITY),
    .WAIT_CYCLES (WAIT_CYCLES),
    .MAX_TRIES   (MAX_TRIES),
    .LOCK_CYCLES (LOCK_CYCLES),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .sensor_leave    (sensor_leave),
    .code_in         (code_in),
    .code_valid      (code_valid),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .HEX_1           (HEX_1),
    .HEX_2           (HEX_2),
    .occupancy       (occupancy),
    .full            (full),
    .locked          (locked)
  );

  typedef struct {
    logic       green;
    logic       red;
    logic [6:0] hex1;
    logic [6:0] hex2;
    int         occ;
    logic       full;
    logic       locked;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_WAIT, M_WRONG, M_RIGHT, M_STOP, M_LOCK} mstate_e;
  mstate_e m_st = M_IDLE;
  int m_occ = 0;
  int m_tries = 0;
  int m_in_state = 0;   // cycles already spent in the current state
  int m_edges = 0;      // clock edges since reset released

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit e, input bit x, input bit l,
                            input bit v, input int c, output exp_t ex);
    mstate_e nxt;
    bit admit, full_now, phase, good;
    if (r) begin
      m_st = M_IDLE; m_occ = 0; m_tries = 0; m_in_state = 0; m_edges = 0;
      ex.green = 0; ex.red = 0; ex.hex1 = 7'h7F; ex.hex2 = 7'h7F;
      ex.occ = 0; ex.full = 0; ex.locked = 0;
      return;
    end
    m_edges++;
    phase    = ((m_edges / BLINK_DIV) % 2) == 1;
    full_now = (m_occ == CAPACITY);
    good     = v && (c == PASSWORD);
    nxt      = m_st;
    admit    = 0;
    case (m_st)
      M_IDLE: if (e && !full_now) nxt = M_WAIT;
      M_WAIT, M_WRONG, M_STOP: begin
        if (good) begin
          m_tries = 0;
          nxt = (m_st == M_STOP && full_now) ? M_STOP : M_RIGHT;
        end else if (v) begin
          m_tries++;
          if (m_tries >= MAX_TRIES) nxt = M_LOCK;
          else nxt = (m_st == M_STOP) ? M_STOP : M_WRONG;
        end else if (m_st == M_WAIT) begin
          if (m_in_state == WAIT_CYCLES - 1) nxt = M_IDLE;
        end else if (!e) begin
          nxt = M_IDLE;
        end
      end
      M_RIGHT: if (x) begin
        admit = 1;
        nxt = (TAILGATE && e) ? M_STOP : M_IDLE;
      end
      M_LOCK: if (m_in_state == LOCK_CYCLES - 1) nxt = M_IDLE;
      default: nxt = M_IDLE;
    endcase
    if (nxt == M_IDLE) m_tries = 0;
    m_in_state = (nxt == m_st) ? m_in_state + 1 : 0;
    m_st = nxt;
    if (admit && !l) m_occ++;
    else if (!admit && l && m_occ > 0) m_occ--;

    ex.green = 0; ex.red = 0;
    case (m_st)
      M_IDLE:         ex.red   = e && full_now;
      M_WAIT, M_LOCK: ex.red   = 1;
      M_WRONG, M_STOP: ex.red  = phase;
      M_RIGHT:        ex.green = phase;
      default:        ex.red   = 0;
    endcase
    if (m_st == M_LOCK) begin
      ex.hex1 = 7'h47; ex.hex2 = 7'h40;
    end else begin
      ex.hex1 = (m_occ / 10 == 0) ? 7'h7F : seg_of(m_occ / 10);
      ex.hex2 = seg_of(m_occ % 10);
    end
    ex.occ    = m_occ;
    ex.full   = (m_occ == CAPACITY);
    ex.locked = (m_st == M_LOCK);
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input bit e, input bit x, input bit l,
                     input bit v, input int c);
    exp_t ex;
    @(negedge clk);
    reset = r; sensor_entrance = e; sensor_exit = x; sensor_leave = l;
    code_valid = v; code_in = 4'(c);
    model_step(r, e, x, l, v, c, ex);
    sb.push_back(ex);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic admit_car();
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 4'hA);
    cyc(0, 0, 1, 0, 0, 0);
    idle(1);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    n_cmp++;
    if (act !== exv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exv);
    end
  endtask

  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        chk("green_led", 32'(GREEN_LED), 32'(ex.green));
        chk("red_led",   32'(RED_LED),   32'(ex.red));
        chk("hex_1",     32'(HEX_1),     32'(ex.hex1));
        chk("hex_2",     32'(HEX_2),     32'(ex.hex2));
        chk("occupancy", 32'(occupancy), 32'(ex.occ));
        chk("full",      32'(full),      32'(ex.full));
        chk("locked",    32'(locked),    32'(ex.locked));
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // single correct admission
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 4'hA);
    cyc(0, 0, 1, 0, 0, 0);
    idle(2);
    // three wrong codes into lockout, correct codes ignored during lockout
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1, 4'h3);
    for (int i = 0; i < 36; i++) cyc(0, i % 3 == 0, 0, 0, i % 5 == 0, 4'hA);
    idle(2);
    // code-entry timeout
    for (int i = 0; i < 18; i++) cyc(0, 1, 0, 0, 0, 0);
    idle(2);
    // fill the lot, refused entry while full, then one leaves
    for (int i = 0; i < 8; i++) admit_car();
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(1);
    // tailgate: exit with entrance still high
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 4'hA);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 4'hA);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 4'hA);
    cyc(0, 0, 1, 0, 0, 0);
    idle(2);
    // leave coincident with admit at 5
    while (m_occ > 5) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 4'hA);
    cyc(0, 0, 1, 1, 0, 0);
    idle(1);
    // leave at zero, then reset mid code entry
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    idle(2);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 1) ? int'(PASSWORD) : int'($urandom_range(0, 15)));
    end
    idle(2);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
